// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, TX FIFO defaults and the launch controller state encoding.
package uart_pkg;

    localparam int WIDTH_DATA = 8;
    localparam int FIFO_WIDTH = WIDTH_DATA;
    localparam int FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_BUSY = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Dual-port register array for the TX FIFO: synchronous write, combinational read.
module uart_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are intentionally not reset; occupancy tracking makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// TX FIFO in front of a UART transmitter: buffers bytes and launches one frame at a time.
//
// state | meaning
// IDLE  | waiting for a queued byte and an idle transmitter
// SEND  | o_TX_valid high for one cycle, head byte on o_TX_DATA
// BUSY  | frame in flight, waiting for i_TX_done
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic                       o_TX_valid,
    output logic [WIDTH-1:0]           o_TX_DATA,
    input  logic                       i_TX_active,
    input  logic                       i_TX_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             pop;
    tx_state_t        state;
    tx_state_t        state_next;

    assign o_full  = (count == CW'(DEPTH));
    assign o_empty = (count == '0);
    assign o_count = count;

    // Full is judged on the pre-edge count, so a same-cycle pop never rescues a write.
    assign push = i_wr_en & ~o_full;
    assign pop  = (state == ST_IDLE) & ~o_empty & ~i_TX_active;

    uart_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (i_clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (i_wr_data),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_TX_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pop) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                o_TX_valid = 1'b1;
                state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (i_TX_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_TX_DATA  <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_overflow <= i_wr_en & o_full;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                o_TX_DATA <= head;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic against a queue model.
module tb_uart_tx_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_wr_en;
    logic [WIDTH-1:0] i_wr_data;
    logic             o_full;
    logic             o_empty;
    logic [4:0]       o_count;
    logic             o_overflow;
    logic             o_TX_valid;
    logic [WIDTH-1:0] o_TX_DATA;
    logic             i_TX_active;
    logic             i_TX_done;

    uart_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wr_en     (i_wr_en),
        .i_wr_data   (i_wr_data),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .o_TX_valid  (o_TX_valid),
        .o_TX_DATA   (o_TX_DATA),
        .i_TX_active (i_TX_active),
        .i_TX_done   (i_TX_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: byte queue, controller phase (0 free, 1 launching, 2 waiting for done).
    logic [WIDTH-1:0] q [$];
    int               phase;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic             exp_ovf;

    // Stand-in transmitter.
    int               tx_timer;
    int               frame_len;
    logic             tx_busy;
    logic             hold_active;
    logic [WIDTH-1:0] launches [$];
    int               launch_counts [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        phase     = 0;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_ovf   = 1'b0;
    endtask

    task automatic model_edge();
        logic full_before;
        full_before = (q.size() == DEPTH);
        exp_ovf     = i_wr_en && full_before;
        case (phase)
            0: if (q.size() > 0 && !i_TX_active) begin
                exp_data = q.pop_front();
                phase    = 1;
            end
            1: phase = 2;
            default: if (i_TX_done) phase = 0;
        endcase
        if (i_wr_en && !full_before) q.push_back(i_wr_data);
        exp_valid = (phase == 1);
    endtask

    task automatic check_all();
        check("count", 32'(o_count), 32'(q.size()));
        check("empty", 32'(o_empty), 32'(q.size() == 0));
        check("full", 32'(o_full), 32'(q.size() == DEPTH));
        check("tx_valid", 32'(o_TX_valid), 32'(exp_valid));
        check("tx_data", 32'(o_TX_DATA), 32'(exp_data));
        check("overflow", 32'(o_overflow), 32'(exp_ovf));
    endtask

    task automatic tick();
        model_edge();
        @(posedge i_clk);
        #1;
        check_all();
        i_TX_done = 1'b0;
        if (tx_timer > 0) begin
            tx_timer--;
            if (tx_timer == 0) begin
                tx_busy   = 1'b0;
                i_TX_done = 1'b1;
            end
        end
        if (o_TX_valid) begin
            tx_timer = frame_len;
            tx_busy  = 1'b1;
            launches.push_back(o_TX_DATA);
            launch_counts.push_back(int'(o_count));
        end
        i_TX_active = tx_busy | hold_active;
    endtask

    task automatic set_hold(input logic h);
        hold_active = h;
        i_TX_active = tx_busy | hold_active;
    endtask

    task automatic wr(input logic [WIDTH-1:0] d);
        i_wr_en   = 1'b1;
        i_wr_data = d;
        tick();
        i_wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain(input int n, input int budget);
        int b;
        b = 0;
        while ((launches.size() < n || q.size() != 0 || tx_busy || phase != 0) && b < budget) begin
            tick();
            b++;
        end
        check("drain_launches", 32'(launches.size()), 32'(n));
    endtask

    task automatic tb_tx_reset();
        tx_timer    = 0;
        tx_busy     = 1'b0;
        hold_active = 1'b0;
        i_TX_active = 1'b0;
        i_TX_done   = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] written [$];
        i_rst_n   = 1'b0;
        i_wr_en   = 1'b0;
        i_wr_data = '0;
        frame_len = 3;
        tb_tx_reset();
        model_reset();
        #1;
        check_all();
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // Single byte: launch in the cycle after the following edge.
        wr(8'h26);
        check("single_not_yet", 32'(o_TX_valid), 32'd0);
        tick();
        check("single_valid", 32'(o_TX_valid), 32'd1);
        check("single_data", 32'(o_TX_DATA), 32'h26);
        tick();
        check("single_one_cycle", 32'(o_TX_valid), 32'd0);
        drain(1, 50);

        // Ordering with counts 3, 2, 1, 0.
        launches.delete();
        launch_counts.delete();
        set_hold(1'b1);
        wr(8'h41);
        wr(8'h42);
        wr(8'h43);
        check("order_count3", 32'(o_count), 32'd3);
        set_hold(1'b0);
        drain(3, 100);
        for (int i = 0; i < 3 && i < launches.size(); i++) begin
            check("order_data", 32'(launches[i]), 32'(8'h41 + i));
            check("order_count", 32'(launch_counts[i]), 32'(2 - i));
        end

        // Overflow: 16 bytes held, 17th dropped.
        launches.delete();
        written.delete();
        set_hold(1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            written.push_back(8'($urandom_range(0, 254)));
            wr(written[i]);
        end
        check("ovf_full", 32'(o_full), 32'd1);
        check("ovf_count16", 32'(o_count), 32'd16);
        wr(8'hFF);
        check("ovf_pulse", 32'(o_overflow), 32'd1);
        check("ovf_count_kept", 32'(o_count), 32'd16);
        tick();
        check("ovf_pulse_end", 32'(o_overflow), 32'd0);
        set_hold(1'b0);
        drain(DEPTH, 400);
        for (int i = 0; i < launches.size() && i < DEPTH; i++) begin
            check("ovf_order", 32'(launches[i]), 32'(written[i]));
        end

        // Write coinciding with a pop at count 1.
        launches.delete();
        set_hold(1'b1);
        wr(8'h5A);
        set_hold(1'b0);
        wr(8'h5B);
        check("simul_count", 32'(o_count), 32'd1);
        check("simul_valid", 32'(o_TX_valid), 32'd1);
        check("simul_data", 32'(o_TX_DATA), 32'h5A);
        drain(2, 60);

        // Reset mid-BUSY with five bytes queued.
        frame_len = 20;
        wr(8'h11);
        for (int i = 0; i < 5; i++) wr(8'(8'h12 + i));
        check("rst_pre_count", 32'(o_count), 32'd5);
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        tb_tx_reset();
        check_all();
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_data", 32'(o_TX_DATA), 32'd0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        frame_len = 3;
        launches.delete();
        idle(10);
        check("rst_no_launch", 32'(launches.size()), 32'd0);
        wr(8'h77);
        tick();
        check("rst_new_launch", 32'(o_TX_DATA), 32'h77);
        drain(1, 50);

        // Spurious done with empty FIFO in IDLE.
        launches.delete();
        i_TX_done = 1'b1;
        tick();
        idle(3);
        check("spur_no_launch", 32'(launches.size()), 32'd0);
        check("spur_empty", 32'(o_empty), 32'd1);

        // Random traffic.
        launches.delete();
        for (int c = 0; c < 1500; c++) begin
            i_wr_en   = ($urandom_range(0, 99) < 45);
            i_wr_data = 8'($urandom);
            if ($urandom_range(0, 99) < 4) set_hold(~hold_active);
            if (!tx_busy && $urandom_range(0, 99) < 3) i_TX_done = 1'b1;
            frame_len = $urandom_range(1, 5);
            tick();
        end
        i_wr_en = 1'b0;
        set_hold(1'b0);
        idle(200);
        check("rand_drained", 32'(o_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
